ex_result_stage: RTL and testbench

Execute-stage result stage for the 16-bit pipelined processor: consumes the 7-bit signed output of the reduction unit and the main ALU result, and selects and sign-extends the writeback value. It computes N/Z/V, updates the architectural flag register per opcode, and registers everything into the EX/MEM pipeline register with stall, flush and halt handling. It sits between the execute datapath (ALU, reduction, shifter) and the memory stage; branch logic reads its flag outputs.

---
 rtl/ex_result_stage.sv | 155 +++++++++++++++
 tb/tb_ex_result_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_result_stage.sv
// Execute-stage result stage: selects and sign-extends the writeback value, maintains the
// N/Z/V flag register and the EX/MEM pipeline register, and tracks the sticky HALT state.
module ex_result_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [3:0]  opcode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic [6:0]  red_result,
  input  logic [3:0]  rd,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] store_data,
  output logic        ex_valid,
  output logic [15:0] ex_result,
  output logic [3:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [15:0] ex_store_data,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_RED = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic        halted_q, halted_d;
  logic        valid_q, valid_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        mr_q, mr_d;
  logic        mw_q, mw_d;
  logic [15:0] sd_q, sd_d;
  logic        z_q, z_d;
  logic        v_q, v_d;
  logic        n_q, n_d;

  logic [15:0] sel_result;
  logic        accept;
  logic        is_hlt;
  logic        live;

  always_comb begin
    sel_result = (opcode == OP_RED) ? {{9{red_result[6]}}, red_result} : alu_result;
    is_hlt     = (opcode == OP_HLT);
    accept     = in_valid & ~stall & ~flush & (state_q == S_RUN);
    // HLT itself travels down the pipe as a valid entry with no side effects
    live       = in_valid & ~is_hlt;

    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    rw_d     = rw_q;
    mr_d     = mr_q;
    mw_d     = mw_q;
    sd_d     = sd_q;
    z_d      = z_q;
    v_d      = v_q;
    n_d      = n_q;

    if (accept) begin
      case (opcode)
        OP_ADD, OP_SUB: begin
          z_d = (sel_result == 16'h0000);
          n_d = sel_result[15];
          v_d = alu_ovfl;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = (sel_result == 16'h0000);
        default: ;
      endcase
      if (is_hlt) state_d = S_HALT;
    end

    if (flush || (!stall && state_q == S_HALT)) begin
      valid_d  = 1'b0;
      result_d = 16'h0000;
      rd_d     = 4'h0;
      rw_d     = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
      sd_d     = 16'h0000;
    end else if (!stall) begin
      valid_d  = in_valid;
      result_d = sel_result;
      rd_d     = rd;
      rw_d     = live & reg_write;
      mr_d     = live & mem_read;
      mw_d     = live & mem_write;
      sd_d     = store_data;
    end

    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      halted_q <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= 16'h0000;
      rd_q     <= 4'h0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      sd_q     <= 16'h0000;
      z_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      rw_q     <= rw_d;
      mr_q     <= mr_d;
      mw_q     <= mw_d;
      sd_q     <= sd_d;
      z_q      <= z_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_result     = result_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
  assign ex_store_data = sd_q;
  assign flag_z        = z_q;
  assign flag_v        = v_q;
  assign flag_n        = n_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Directed bench for ex_result_stage: each step pushes the expected post-edge state to a
// queue, and the value is popped and compared once the DUT has registered the step.
module tb_ex_result_stage;

  localparam int W = 44;

  logic        clk, rst, stall, flush, in_valid;
  logic [3:0]  opcode;
  logic [15:0] alu_result;
  logic        alu_ovfl;
  logic [6:0]  red_result;
  logic [3:0]  rd;
  logic        reg_write, mem_read, mem_write;
  logic [15:0] store_data;
  logic        ex_valid;
  logic [15:0] ex_result;
  logic [3:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [15:0] ex_store_data;
  logic        flag_z, flag_v, flag_n, halted;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  ex_result_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .alu_result(alu_result), .alu_ovfl(alu_ovfl),
    .red_result(red_result), .rd(rd), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .store_data(store_data), .ex_valid(ex_valid),
    .ex_result(ex_result), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .flag_z(flag_z), .flag_v(flag_v),
    .flag_n(flag_n), .halted(halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed view: {valid, result, rd, rw, mr, mw, store, z, v, n, halted}
  function automatic logic [W-1:0] pack(input logic v, input logic [15:0] res,
                                        input logic [3:0] r, input logic rw, input logic mr,
                                        input logic mw, input logic [15:0] sd, input logic z,
                                        input logic fv, input logic n, input logic h);
    return {v, res, r, rw, mr, mw, sd, z, fv, n, h};
  endfunction

  function automatic logic [W-1:0] observed();
    return pack(ex_valid, ex_result, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                ex_store_data, flag_z, flag_v, flag_n, halted);
  endfunction

  // scoreboard
  task automatic check_out(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<empty queue>", tag, observed());
    end else begin
      exp_v = exp_q.pop_front();
      obs_v = observed();
      assert (obs_v === exp_v) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs_v, exp_v);
      end
    end
  endtask

  // driver
  task automatic drive(input logic iv, input logic [3:0] op, input logic [15:0] alu,
                       input logic ovf, input logic [6:0] red, input logic [3:0] r,
                       input logic rw, input logic mr, input logic mw,
                       input logic [15:0] sd, input logic st, input logic fl);
    @(negedge clk);
    in_valid = iv; opcode = op; alu_result = alu; alu_ovfl = ovf; red_result = red;
    rd = r; reg_write = rw; mem_read = mr; mem_write = mw; store_data = sd;
    stall = st; flush = fl;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; opcode = 4'h0;
    alu_result = 16'h0; alu_ovfl = 1'b0; red_result = 7'h0; rd = 4'h0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; store_data = 16'h0;
    #12;
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
    check_out("reset");
    @(negedge clk);
    rst = 1'b0;

    // RED sign extension, flags untouched
    drive(1, 4'b0011, 16'h7777, 0, 7'h41, 4'd3, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'hFFC1, 4'd3, 1, 0, 0, 16'h0, 0, 0, 0, 0));
    step("red_neg");
    drive(1, 4'b0011, 16'h7777, 1, 7'h3F, 4'd4, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h003F, 4'd4, 1, 0, 0, 16'h0, 0, 0, 0, 0));
    step("red_pos");

    // flag update classes
    drive(1, 4'b0000, 16'h0000, 1, 7'h0, 4'd1, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h0000, 4'd1, 1, 0, 0, 16'h0, 1, 1, 0, 0));
    step("add_zero_ovf");
    drive(1, 4'b0010, 16'h8000, 0, 7'h0, 4'd2, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h8000, 4'd2, 1, 0, 0, 16'h0, 0, 1, 0, 0));
    step("xor_z_only");
    drive(1, 4'b1000, 16'h0000, 1, 7'h0, 4'd5, 1, 1, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h0000, 4'd5, 1, 1, 0, 16'h0, 0, 1, 0, 0));
    step("lw_flags_held");
    drive(1, 4'b0001, 16'h8001, 0, 7'h0, 4'd6, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h8001, 4'd6, 1, 0, 0, 16'h0, 0, 0, 1, 0));
    step("sub_neg");

    // three stalled cycles hold everything, then the ADD lands
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0000, 16'h1234, 1, 7'h0, 4'd7, 1, 0, 0, 16'h0, 1, 0);
      exp_q.push_back(pack(1, 16'h8001, 4'd6, 1, 0, 0, 16'h0, 0, 0, 1, 0));
      step($sformatf("stall_hold_%0d", i));
    end
    drive(1, 4'b0000, 16'h1234, 0, 7'h0, 4'd7, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h1234, 4'd7, 1, 0, 0, 16'h0, 0, 0, 0, 0));
    step("add_after_stall");

    // flush beats stall; flush blocks flag update
    drive(1, 4'b1001, 16'h0010, 0, 7'h0, 4'd0, 0, 0, 1, 16'hABCD, 1, 1);
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
    step("flush_and_stall");
    drive(1, 4'b0000, 16'h0000, 1, 7'h0, 4'd1, 1, 0, 0, 16'h0, 0, 1);
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
    step("flush_add");

    // invalid slot: data loads, controls gated, flags held
    drive(0, 4'b0000, 16'h0000, 1, 7'h0, 4'd9, 1, 1, 1, 16'h1111, 0, 0);
    exp_q.push_back(pack(0, 16'h0000, 4'd9, 0, 0, 0, 16'h1111, 0, 0, 0, 0));
    step("invalid_slot");

    // valid SW passes its store data and write enable
    drive(1, 4'b1001, 16'h0020, 0, 7'h0, 4'd0, 0, 0, 1, 16'hBEEF, 0, 0);
    exp_q.push_back(pack(1, 16'h0020, 4'd0, 0, 0, 1, 16'hBEEF, 0, 0, 0, 0));
    step("sw");

    // HLT then ADD: bubble, frozen flags
    drive(1, 4'b1111, 16'hAAAA, 0, 7'h0, 4'd8, 1, 1, 1, 16'h2222, 0, 0);
    exp_q.push_back(pack(1, 16'hAAAA, 4'd8, 0, 0, 0, 16'h2222, 0, 0, 0, 1));
    step("hlt");
    drive(1, 4'b0000, 16'h0000, 1, 7'h0, 4'd1, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
    step("halt_bubble");
    drive(1, 4'b0000, 16'h8000, 1, 7'h0, 4'd1, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 1));
    step("halt_sticky");

    // reset leaves HALT
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
    check_out("reset_from_halt");
    @(negedge clk);
    rst = 1'b0;

    // drive Z=N=V=1, then reset asynchronously mid-stall
    drive(1, 4'b0000, 16'h8000, 1, 7'h0, 4'd3, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h8000, 4'd3, 1, 0, 0, 16'h0, 0, 1, 1, 0));
    step("add_neg_ovf");
    drive(1, 4'b0101, 16'h0000, 0, 7'h0, 4'd4, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h0000, 4'd4, 1, 0, 0, 16'h0, 1, 1, 1, 0));
    step("sra_zero");
    drive(1, 4'b0000, 16'h5555, 0, 7'h0, 4'd5, 1, 0, 0, 16'h0, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(pack(0, 16'h0, 4'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0));
    check_out("async_reset_mid_stall");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 4'b0000, 16'h0010, 0, 7'h0, 4'd2, 1, 0, 0, 16'h0, 0, 0);
    exp_q.push_back(pack(1, 16'h0010, 4'd2, 1, 0, 0, 16'h0, 0, 0, 0, 0));
    step("add_after_reset");

    // randomized RED sign-extension sweep
    for (int i = 0; i < 8; i++) begin
      logic [6:0] r7;
      r7 = 7'($urandom_range(0, 127));
      drive(1, 4'b0011, 16'h0, 0, r7, 4'd1, 1, 0, 0, 16'h0, 0, 0);
      exp_q.push_back(pack(1, {{9{r7[6]}}, r7}, 4'd1, 1, 0, 0, 16'h0, 0, 0, 0, 0));
      step($sformatf("red_rand_%0d", i));
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
